// File: rtl/serial_frame_feeder_if.sv
// Load-side handshake bundle for serial_frame_feeder.
// Master offers words, slave (the feeder) accepts them.
interface serial_frame_feeder_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready
   );
endinterface

// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial feeder for bit-serial detectors.
// Streams words back to back with no idle bit between them.
module serial_frame_feeder #(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_frame_feeder_if.slave ld,
   input  logic                 en,
   output logic                 ser_out,
   output logic                 ser_valid,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;
   logic             ser_d;
   logic             done_d;
   logic             last;
   logic             accept;
   logic             load_first;
   logic             sreg_first;
   logic [WIDTH-1:0] load_rest;
   logic [WIDTH-1:0] sreg_rest;

   // The shift register always holds the bits still to be sent,
   // with the next one at the end selected by the bit order.
   generate
      if (MSB_FIRST) begin : g_msb
         assign load_first = ld.load_data[WIDTH-1];
         assign load_rest  = {ld.load_data[WIDTH-2:0], 1'b0};
         assign sreg_first = sreg_q[WIDTH-1];
         assign sreg_rest  = {sreg_q[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign load_first = ld.load_data[0];
         assign load_rest  = {1'b0, ld.load_data[WIDTH-1:1]};
         assign sreg_first = sreg_q[0];
         assign sreg_rest  = {1'b0, sreg_q[WIDTH-1:1]};
      end
   endgenerate

   assign last   = (state_q == SHIFT) && (count_q == LAST);
   assign accept = ld.load_valid && ld.load_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: leave SHIFT only when the last bit goes out unreplaced.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last && en && !accept) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Ready when idle, or when the last bit is leaving this edge.
   always_comb begin
      ld.load_ready = !rst &&
                      ((state_q == IDLE) || (last && en));
   end

   // Datapath next values: load, shift, or drop back to idle level.
   always_comb begin
      count_d = count_q;
      sreg_d  = sreg_q;
      ser_d   = ser_out;
      if (accept) begin
         count_d = '0;
         sreg_d  = load_rest;
         ser_d   = load_first;
      end else if ((state_q == SHIFT) && en) begin
         if (!last) begin
            count_d = count_q + 1'b1;
            sreg_d  = sreg_rest;
            ser_d   = sreg_first;
         end else begin
            count_d = '0;
            ser_d   = IDLE_BIT;
         end
      end
      done_d = (state_d == SHIFT) && (count_d == LAST);
   end

   // Datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         sreg_q    <= '0;
         ser_out   <= IDLE_BIT;
         ser_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         count_q   <= count_d;
         sreg_q    <= sreg_d;
         ser_out   <= ser_d;
         ser_valid <= (state_d == SHIFT);
         busy      <= (state_d == SHIFT);
         done      <= done_d;
      end
   end

endmodule
